// File: rtl/zclk_turbo_ctl.sv
// zclk_turbo_ctl
//
// Turbo-mode controller for the Z80 clock generator. Resolves the
// CPU-requested speed (config register) and the peripheral force-slow
// request into the turbo code the clock generator consumes. The code
// only changes on fclk cycles without a zpos strobe, so the generator's
// refresh-edge latch never samples a changing value. The speed the
// generator has actually adopted is mirrored on eff_turbo.
//
// Ports:
//   fclk        in   system clock (28 MHz)
//   rst_n       in   asynchronous active-low reset
//   zpos        in   one-fclk strobe, Z80 clock rising edge
//   rfsh_n      in   Z80 RFSH (active-low), fclk domain
//   cfg_wr      in   write strobe for the turbo config register
//   cfg_turbo   in   requested speed: 00 = 3.5, 01 = 7, 1x = 14 MHz
//   slow_req    in   level request to force 3.5 MHz
//   turbo       out  code driven to the clock generator
//   eff_turbo   out  speed the generator is running at
//   pending     out  eff_turbo differs from the current target
//   slow_active out  force-slow FSM is not in RUN

module zclk_turbo_ctl #(
    parameter int unsigned HOLD_ZCYC = 64,
    parameter bit          ALLOW_14  = 1'b0
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       zpos,
    input  logic       rfsh_n,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_turbo,
    input  logic       slow_req,
    output logic [1:0] turbo,
    output logic [1:0] eff_turbo,
    output logic       pending,
    output logic       slow_active
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_SLOW = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_ZCYC);

    state_t      state, state_nx;
    logic [15:0] hcnt, hcnt_nx;
    logic [1:0]  req;
    logic [1:0]  target;
    logic        old_rfsh;

    // 14 MHz requests fall back to 7 MHz unless the build allows 14 MHz.
    function automatic logic [1:0] clamp_turbo(input logic [1:0] t);
        if (!ALLOW_14 && t[1])
            return 2'b01;
        return t;
    endfunction

    // Request register
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)
            req <= 2'b00;
        else if (cfg_wr)
            req <= clamp_turbo(cfg_turbo);
    end

    // Force-slow FSM: HOLD keeps 3.5 MHz for HOLD_ZCYC zpos strobes after
    // slow_req drops; a new slow_req abandons the count.
    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        case (state)
            ST_RUN: begin
                if (slow_req)
                    state_nx = ST_SLOW;
            end
            ST_SLOW: begin
                if (!slow_req) begin
                    state_nx = ST_HOLD;
                    hcnt_nx  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (slow_req)
                    state_nx = ST_SLOW;
                else if (hcnt == 16'd0)
                    state_nx = ST_RUN;
                else if (zpos)
                    hcnt_nx = hcnt - 16'd1;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            hcnt  <= 16'd0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
        end
    end

    assign slow_active = (state != ST_RUN);
    assign target      = slow_active ? 2'b00 : req;

    // Output code: frozen on zpos cycles so the generator's latch is safe.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)
            turbo <= 2'b00;
        else if (!zpos)
            turbo <= target;
    end

    // Mirror: same RFSH falling edge, sampled on zpos, that the generator uses.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            old_rfsh  <= 1'b1;
            eff_turbo <= 2'b00;
        end else if (zpos) begin
            old_rfsh <= rfsh_n;
            if (old_rfsh && !rfsh_n)
                eff_turbo <= turbo;
        end
    end

    assign pending = (eff_turbo != target);

endmodule

// File: tb/tb_zclk_turbo_ctl.sv
// Scoreboard bench for zclk_turbo_ctl. Three instances share the stimulus:
//   u0: HOLD_ZCYC=4, ALLOW_14=0
//   u1: HOLD_ZCYC=4, ALLOW_14=1
//   u2: HOLD_ZCYC=0, ALLOW_14=0
// The driver applies inputs on the falling edge and pushes the outputs the
// reference model predicts after the next rising edge; the monitor pops and
// compares shortly after each rising edge.

module tb_zclk_turbo_ctl;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       zpos, rfsh_n, cfg_wr, slow_req;
    logic [1:0] cfg_turbo;

    logic [1:0] d_turbo [3];
    logic [1:0] d_eff   [3];
    logic       d_pend  [3];
    logic       d_slow  [3];

    always #5 fclk = ~fclk;

    zclk_turbo_ctl #(.HOLD_ZCYC(4), .ALLOW_14(1'b0)) u0 (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .rfsh_n(rfsh_n),
        .cfg_wr(cfg_wr), .cfg_turbo(cfg_turbo), .slow_req(slow_req),
        .turbo(d_turbo[0]), .eff_turbo(d_eff[0]), .pending(d_pend[0]),
        .slow_active(d_slow[0]));

    zclk_turbo_ctl #(.HOLD_ZCYC(4), .ALLOW_14(1'b1)) u1 (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .rfsh_n(rfsh_n),
        .cfg_wr(cfg_wr), .cfg_turbo(cfg_turbo), .slow_req(slow_req),
        .turbo(d_turbo[1]), .eff_turbo(d_eff[1]), .pending(d_pend[1]),
        .slow_active(d_slow[1]));

    zclk_turbo_ctl #(.HOLD_ZCYC(0), .ALLOW_14(1'b0)) u2 (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .rfsh_n(rfsh_n),
        .cfg_wr(cfg_wr), .cfg_turbo(cfg_turbo), .slow_req(slow_req),
        .turbo(d_turbo[2]), .eff_turbo(d_eff[2]), .pending(d_pend[2]),
        .slow_active(d_slow[2]));

    typedef struct packed {
        logic [2:0][1:0] turbo;
        logic [2:0][1:0] eff;
        logic [2:0]      pend;
        logic [2:0]      slow;
    } exp_t;

    exp_t q[$];

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input int inst, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s[u%0d] @%0t: got %0d expected %0d", name, inst, $time, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Speed-level view: "slow" is a phase (none / forced / holding with a
    // number of zpos strobes still to wait).
    int         m_phase [3];   // 0 none, 1 forced, 2 holding
    int         m_left  [3];
    logic [1:0] m_req   [3];
    logic [1:0] m_tb    [3];
    logic [1:0] m_eff   [3];
    logic       m_old   [3];

    function automatic int hold_of(input int i);
        return (i == 2) ? 0 : 4;
    endfunction

    function automatic logic [1:0] speed_req(input int i, input logic [1:0] t);
        int v;
        v = int'(t);
        if (v >= 2 && i != 1) v = 1;
        return 2'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_phase[i] = 0; m_left[i] = 0;
            m_req[i] = 2'b00; m_tb[i] = 2'b00; m_eff[i] = 2'b00; m_old[i] = 1'b1;
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.turbo[i] = m_tb[i];
            e.eff[i]   = m_eff[i];
            e.slow[i]  = (m_phase[i] != 0);
            e.pend[i]  = (m_eff[i] != ((m_phase[i] != 0) ? 2'b00 : m_req[i]));
        end
        return e;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic [1:0] tgt;
            int         ph, lf;
            tgt = (m_phase[i] != 0) ? 2'b00 : m_req[i];
            ph = m_phase[i];
            lf = m_left[i];
            if (m_phase[i] == 0 && slow_req) ph = 1;
            else if (m_phase[i] == 1 && !slow_req) begin ph = 2; lf = hold_of(i); end
            else if (m_phase[i] == 2) begin
                if (slow_req) ph = 1;
                else if (m_left[i] == 0) ph = 0;
                else if (zpos) lf = m_left[i] - 1;
            end
            if (zpos && m_old[i] && !rfsh_n) m_eff[i] = m_tb[i];
            if (zpos) m_old[i] = rfsh_n;
            if (!zpos) m_tb[i] = tgt;
            if (cfg_wr) m_req[i] = speed_req(i, cfg_turbo);
            m_phase[i] = ph;
            m_left[i]  = lf;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic w, input logic [1:0] ct, input logic sr,
                       input logic zp, input logic rf);
        @(negedge fclk);
        rst_n = 1'b1; cfg_wr = w; cfg_turbo = ct; slow_req = sr; zpos = zp; rfsh_n = rf;
        model_step();
        q.push_back(model_outputs());
    endtask

    task automatic idle(input int n, input logic sr, input int zper);
        for (int k = 0; k < n; k++)
            cyc(1'b0, 2'b00, sr, (k % zper) == zper - 1, 1'b1);
    endtask

    // Pulse RFSH low across a zpos so the mirror sees a falling edge.
    task automatic rfsh_pulse(input logic sr);
        cyc(1'b0, 2'b00, sr, 1'b1, 1'b1);
        cyc(1'b0, 2'b00, sr, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, sr, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, sr, 1'b0, 1'b1);
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            check({name, "_turbo"}, i, d_turbo[i], 0);
            check({name, "_eff"},   i, d_eff[i],   0);
            check({name, "_pend"},  i, d_pend[i],  0);
            check({name, "_slow"},  i, d_slow[i],  0);
        end
    endtask

    task automatic async_reset();
        @(negedge fclk);
        #1 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        q.push_back(model_outputs());
        @(negedge fclk);
        model_reset();
        q.push_back(model_outputs());
    endtask

    // ---------------- monitor ----------------
    logic [1:0] prev_tb [3];
    bit         prev_ok = 1'b0;

    initial begin
        forever begin
            @(posedge fclk);
            #2;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    check("turbo",       i, d_turbo[i], e.turbo[i]);
                    check("eff_turbo",   i, d_eff[i],   e.eff[i]);
                    check("pending",     i, d_pend[i],  e.pend[i]);
                    check("slow_active", i, d_slow[i],  e.slow[i]);
                    if (prev_ok && rst_n && zpos)
                        check("zpos_stable", i, d_turbo[i], prev_tb[i]);
                end
            end
            for (int i = 0; i < 3; i++) prev_tb[i] = d_turbo[i];
            prev_ok = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; zpos = 1'b0; rfsh_n = 1'b1; cfg_wr = 1'b0;
        cfg_turbo = 2'b00; slow_req = 1'b0;
        model_reset();
        repeat (3) @(posedge fclk);
        #1 check_zero("reset");

        // Request 7 MHz, then let a refresh edge commit it to the mirror.
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0, 100);
        rfsh_pulse(1'b0);
        idle(3, 1'b0, 3);

        // 14 MHz request: clamped or passed depending on ALLOW_14.
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0, 3);
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0, 3);
        rfsh_pulse(1'b0);

        // Force slow, then release and count the hold window.
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b1, 3);
        idle(20, 1'b0, 3);

        // Re-assert during HOLD after two zpos strobes, then a full release.
        idle(5, 1'b1, 3);
        idle(7, 1'b0, 3);
        idle(4, 1'b1, 3);
        idle(20, 1'b0, 3);

        // Write while zpos is held high: turbo must wait for a zpos=0 cycle.
        cyc(1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b0, 100);
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0, 100);
        rfsh_pulse(1'b0);

        // Reset in the middle of HOLD with eff_turbo = 01.
        idle(4, 1'b1, 3);
        idle(3, 1'b0, 3);
        async_reset();

        // Randomized run.
        begin
            logic sr, rf;
            sr = 1'b0; rf = 1'b1;
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(0, 39) == 0) sr = ~sr;
                if ($urandom_range(0, 3) == 0)  rf = ~rf;
                if ($urandom_range(0, 1499) == 0)
                    async_reset();
                else
                    cyc($urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)), sr,
                        $urandom_range(0, 2) == 0, rf);
            end
        end

        @(negedge fclk);
        repeat (2) @(posedge fclk);
        #5;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
